// File: rtl/sipo_deserializer_ne.sv
// Falling-edge serial-in/parallel-out deserializer: assembles WIDTH-bit words MSB-first.
// Optional even-parity trailer enabled by defining SIPO_PARITY_EN; otherwise PERR is tied low.
module sipo_deserializer_ne #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             RST_N,
    input  logic             D,
    input  logic             EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             PERR
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   shifted;
    logic               last_bit;
`ifdef SIPO_PARITY_EN
    logic               perr_q, perr_d;
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d   = perr_q;
`endif
        shifted  = {sr_q[WIDTH-2:0], D};
        last_bit = (cnt_q == CNT_W'(FRAME - 1));

        if (CLR) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else if (EN) begin
            case (state_q)
                IDLE: begin
                    sr_d    = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = RECV;
                end
                RECV: begin
                    if (last_bit) begin
`ifdef SIPO_PARITY_EN
                        // Final bit is the parity trailer: data already sits whole in sr_q.
                        dout_d = sr_q;
                        perr_d = ^{sr_q, D};
`else
                        dout_d = shifted;
                        sr_d   = shifted;
`endif
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sr_d  = shifted;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(negedge C or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(negedge C or negedge RST_N) begin
        if (!RST_N) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign BUSY  = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deserializer_ne.sv
// Bench for sipo_deserializer_ne: queue-based frame model checked every rising edge,
// plus directed literal checks; inputs change 2 time units after each falling edge.
module tb_sipo_deserializer_ne;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         C = 1'b1;
    logic         RST_N = 1'b0;
    logic         D = 1'b0;
    logic         EN = 1'b0;
    logic         CLR = 1'b0;
    logic [W-1:0] DOUT;
    logic         VALID;
    logic         BUSY;
    logic         PERR;

    int vectors = 0;
    int miscompares = 0;
    bit running = 1'b0;

    sipo_deserializer_ne #(.WIDTH(W)) dut (
        .C(C), .RST_N(RST_N), .D(D), .EN(EN), .CLR(CLR),
        .DOUT(DOUT), .VALID(VALID), .BUSY(BUSY), .PERR(PERR)
    );

    always #5 C = ~C;

    // Model: bits of the current frame in arrival order.
    int           q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_valid = 1'b0;
    logic         m_perr = 1'b0;

    always @(negedge C or negedge RST_N) begin
        if (!RST_N) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_perr  = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (CLR) begin
                q.delete();
            end else if (EN) begin
                q.push_back(D ? 1 : 0);
                if (q.size() == FRAME) begin
                    int w;
                    int ones;
                    w = 0;
                    ones = 0;
                    for (int i = 0; i < W; i++) w = w * 2 + q[i];
                    for (int i = 0; i < FRAME; i++) ones = ones + q[i];
                    m_dout  = W'(w);
`ifdef SIPO_PARITY_EN
                    m_perr  = (ones % 2) != 0;
`else
                    if (ones < 0) m_perr = 1'b1;
`endif
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge C) begin
        if (running) begin
            check("cmp_dout",  32'(DOUT),  32'(m_dout));
            check("cmp_valid", 32'(VALID), 32'(m_valid));
            check("cmp_busy",  32'(BUSY),  32'(q.size() != 0));
            check("cmp_perr",  32'(PERR),  32'(m_perr));
        end
    end

    task automatic step(input logic d, input logic en, input logic clr);
        D   = d;
        EN  = en;
        CLR = clr;
        @(negedge C);
        #2;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        step(^w, 1'b1, 1'b0);
`endif
    endtask

    task automatic async_reset_pulse();
        #1;
        RST_N = 1'b0;
        #1;
        check("async_rst_dout",  32'(DOUT),  0);
        check("async_rst_valid", 32'(VALID), 0);
        check("async_rst_busy",  32'(BUSY),  0);
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] basic;
        basic = 4'b1011;
        running = 1'b1;

        // Reset held while clocking with D=1, EN=1.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("rst_dout",  32'(DOUT),  0);
            check("rst_valid", 32'(VALID), 0);
            check("rst_busy",  32'(BUSY),  0);
        end
        RST_N = 1'b1;

        // Basic word 1,0,1,1.
        for (int i = 3; i >= 1; i--) begin
            step(basic[i], 1'b1, 1'b0);
            check("basic_busy", 32'(BUSY), 1);
        end
        step(basic[0], 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        check("basic_busy_par", 32'(BUSY), 1);
        step(1'b1, 1'b1, 1'b0);
        check("par_ok_perr", 32'(PERR), 0);
`endif
        check("basic_dout",  32'(DOUT),  32'h0000000b);
        check("basic_valid", 32'(VALID), 1);
        check("model_basic", 32'(m_dout), 32'h0000000b);
        step(1'b0, 1'b0, 1'b0);
        check("basic_valid_drop", 32'(VALID), 0);
        check("basic_dout_hold",  32'(DOUT),  32'h0000000b);

        // Back-to-back 1100 then 0101 with a 3-cycle stall after bit 2.
        send_word(4'b1100);
        check("b2b_dout1",  32'(DOUT),  32'h0000000c);
        check("b2b_valid1", 32'(VALID), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("stall_busy",  32'(BUSY),  1);
            check("stall_valid", 32'(VALID), 0);
            check("stall_dout",  32'(DOUT),  32'h0000000c);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        check("b2b_dout2",  32'(DOUT),  32'h00000005);
        check("b2b_valid2", 32'(VALID), 1);
        check("model_b2b",  32'(m_dout), 32'h00000005);

        // Abort with CLR on bit 4.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("abort_valid", 32'(VALID), 0);
        check("abort_dout",  32'(DOUT),  32'h00000005);
        check("abort_busy",  32'(BUSY),  0);
        send_word(4'b0010);
        check("after_abort_dout",  32'(DOUT),  32'h00000002);
        check("after_abort_valid", 32'(VALID), 1);

`ifdef SIPO_PARITY_EN
        // Bad parity trailer.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("par_bad_dout",  32'(DOUT),  32'h0000000b);
        check("par_bad_perr",  32'(PERR),  1);
        check("par_bad_valid", 32'(VALID), 1);
        check("model_par_bad", 32'(m_perr), 1);
`endif

        // Mid-frame asynchronous reset, then 0110.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        async_reset_pulse();
        send_word(4'b0110);
        check("midrst_dout",  32'(DOUT),  32'h00000006);
        check("midrst_valid", 32'(VALID), 1);
        step(1'b0, 1'b0, 1'b0);
        check("midrst_single_valid", 32'(VALID), 0);

        // Randomized traffic, mostly enabled so back-to-back frames occur.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse();
            end else begin
                step(1'($urandom_range(0, 1)),
                     $urandom_range(0, 4) != 0,
                     $urandom_range(0, 24) == 0);
            end
        end

        step(1'b0, 1'b0, 1'b0);
        @(posedge C);
        #1;
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
